// File: rtl/core_pkg.sv
// Shared core types: IFU state encoding, NOP encoding and the default reset PC.
package core_pkg;

    typedef enum logic [2:0] {
        S_REQ     = 3'd0,
        S_RSP     = 3'd1,
        S_SEND    = 3'd2,
        S_WAIT_PC = 3'd3,
        S_HALT    = 3'd4
    } ifu_state_t;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ifu_if.sv
// Fetch-stage bundle: imem request/response, decode handoff, next-PC update and status.
interface ifu_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic        imem_rsp_ready;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        ifu_valid;
    logic [63:0] ifu_data;
    logic        idu_ready;
    logic        pc_upd_valid;
    logic [31:0] pc_upd_target;
    logic        fetch_err;
    logic [31:0] fetch_cnt;

    modport master (
        output imem_req_valid, imem_addr, imem_rsp_ready,
        output ifu_valid, ifu_data, fetch_err, fetch_cnt,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        input  idu_ready, pc_upd_valid, pc_upd_target
    );

    modport slave (
        input  imem_req_valid, imem_addr, imem_rsp_ready,
        input  ifu_valid, ifu_data, fetch_err, fetch_cnt,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        output idu_ready, pc_upd_valid, pc_upd_target
    );

endinterface

// File: rtl/ifu.sv
// Instruction fetch: one imem read per instruction, handed to decode as {inst, pc}; >=3 cycles from PC update to ifu_valid.
// Request and decode outputs hold stable under backpressure; bus error or misaligned target halts until reset.
module ifu
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic  clk,
    input  logic  rst,
    ifu_if.master bus
);

    ifu_state_t  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        fetch_err_q, fetch_err_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            inst_q      <= NOP_INST;
            fetch_err_q <= 1'b0;
            fetch_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            fetch_err_q <= fetch_err_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        fetch_err_d = fetch_err_q;
        fetch_cnt_d = fetch_cnt_q;
        case (state_q)
            S_REQ: begin
                if (bus.imem_req_ready) state_d = S_RSP;
            end
            S_RSP: begin
                if (bus.imem_rsp_valid) begin
                    if (bus.imem_rsp_err) begin
                        fetch_err_d = 1'b1;
                        state_d     = S_HALT;
                    end else begin
                        inst_d  = bus.imem_rsp_data;
                        state_d = S_SEND;
                    end
                end
            end
            S_SEND: begin
                if (bus.idu_ready) begin
                    fetch_cnt_d = fetch_cnt_q + 32'd1;
                    state_d     = S_WAIT_PC;
                end
            end
            S_WAIT_PC: begin
                // Misaligned targets halt without disturbing pc, so the faulting fetch stays visible.
                if (bus.pc_upd_valid) begin
                    if (bus.pc_upd_target[1:0] == 2'b00) begin
                        pc_d    = bus.pc_upd_target;
                        state_d = S_REQ;
                    end else begin
                        fetch_err_d = 1'b1;
                        state_d     = S_HALT;
                    end
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    assign bus.imem_req_valid = !rst && (state_q == S_REQ);
    assign bus.imem_rsp_ready = !rst && (state_q == S_RSP);
    assign bus.ifu_valid      = !rst && (state_q == S_SEND);
    assign bus.imem_addr      = pc_q;
    assign bus.ifu_data       = {inst_q, pc_q};
    assign bus.fetch_err      = fetch_err_q;
    assign bus.fetch_cnt      = fetch_cnt_q;

endmodule
